// File: rtl/game_pacer.sv
// Gameplay timing core: NCH tick channels whose periods shorten on every acceleration event,
// the IDLE/RUN/CRASH run-state FSM and a saturating seconds score. Optional: GAME_PACER_BLINK_EN.
module game_pacer #(
  parameter int NCH          = 3,
  parameter int CW           = 26,
  parameter int ACCEL_CYCLES = 100000000,
  parameter int SEC_CYCLES   = 50000000,
  parameter int CRASH_CYCLES = 100000000,
  parameter int SCORE_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 colision,
  input  logic [NCH*CW-1:0]    base_period,
  input  logic [NCH*CW-1:0]    step,
  input  logic [NCH*CW-1:0]    min_period,
  output logic [NCH-1:0]       tick,
  output logic                 running,
  output logic                 crashed,
  output logic                 accel_pulse,
  output logic [SCORE_W-1:0]   score,
  output logic                 crash_blink
);

  localparam int AW = (ACCEL_CYCLES > 1) ? $clog2(ACCEL_CYCLES) : 1;
  localparam int SW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam int XW = (CRASH_CYCLES > 1) ? $clog2(CRASH_CYCLES) : 1;
  localparam logic [AW-1:0] ACCEL_LAST = AW'(ACCEL_CYCLES - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_CYCLES - 1);
  localparam logic [XW-1:0] CRASH_LAST = XW'(CRASH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt        [NCH];
  logic [CW-1:0]   period_reg [NCH];
  logic [AW-1:0]   accel_cnt;
  logic [SW-1:0]   sec_cnt;
  logic [XW-1:0]   crash_cnt;
  logic            in_run;
  logic            in_crash;
  logic            accel_hit;
  logic            sec_hit;
  logic            crash_done;

  // Subtraction is one bit wider than the period so an oversized step clamps to the floor.
  function automatic logic [CW-1:0] accel_period(input logic [CW-1:0] cur,
                                                 input logic [CW-1:0] dec,
                                                 input logic [CW-1:0] floor_p);
    logic signed [CW:0] diff;
    diff = $signed({1'b0, cur}) - $signed({1'b0, dec});
    if (diff < $signed({1'b0, floor_p}))
      return floor_p;
    return diff[CW-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  assign in_run      = (state == RUN);
  assign in_crash    = (state == CRASH);
  assign accel_hit   = in_run && (accel_cnt == ACCEL_LAST);
  assign sec_hit     = in_run && (sec_cnt == SEC_LAST);
  assign crash_done  = in_crash && (crash_cnt == CRASH_LAST);
  assign accel_pulse = accel_hit;

  // A count already past a freshly shortened period fires next cycle instead of wrapping.
  always_comb begin
    tick = '0;
    for (int i = 0; i < NCH; i++) begin
      if (in_run && (({1'b0, cnt[i]} + (CW+1)'(1)) >= {1'b0, period_reg[i]}))
        tick[i] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)      state_next = RUN;
      RUN:     if (colision)   state_next = CRASH;
      CRASH:   if (crash_done) state_next = RUN;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
      crashed <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      crashed <= (state_next == CRASH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]        <= '0;
        period_reg[i] <= '0;
      end
      accel_cnt <= '0;
      sec_cnt   <= '0;
      crash_cnt <= '0;
      score     <= '0;
    end else begin
      case (state)
        IDLE: begin
          for (int i = 0; i < NCH; i++) begin
            cnt[i]        <= '0;
            period_reg[i] <= base_period[i*CW +: CW];
          end
          accel_cnt <= '0;
          sec_cnt   <= '0;
          crash_cnt <= '0;
        end
        RUN: begin
          crash_cnt <= '0;
          for (int i = 0; i < NCH; i++) begin
            cnt[i] <= tick[i] ? '0 : cnt[i] + CW'(1);
            if (accel_hit)
              period_reg[i] <= accel_period(period_reg[i], step[i*CW +: CW],
                                            min_period[i*CW +: CW]);
          end
          accel_cnt <= accel_hit ? '0 : accel_cnt + AW'(1);
          if (sec_hit) begin
            sec_cnt <= '0;
            score   <= score_inc(score);
          end else begin
            sec_cnt <= sec_cnt + SW'(1);
          end
        end
        CRASH: begin
          // Leaving CRASH costs the player all accumulated speed.
          if (crash_done) begin
            crash_cnt <= '0;
            accel_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
              cnt[i]        <= '0;
              period_reg[i] <= base_period[i*CW +: CW];
            end
          end else begin
            crash_cnt <= crash_cnt + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GAME_PACER_BLINK_EN
  localparam int BW = CW / 2;
  logic [BW:0] blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      blink_cnt <= '0;
    else if (in_crash)
      blink_cnt <= blink_cnt + (BW+1)'(1);
    else
      blink_cnt <= '0;
  end

  assign crash_blink = in_crash && !blink_cnt[BW];
`else
  assign crash_blink = 1'b0;
`endif

endmodule

// File: doc/game_pacer.md
Name: game_pacer

Overview:
Parametrised timing core for the road-fighter game. It generates NCH independent gameplay tick channels, for example scroll, fast scroll and enemy drop. Each channel has its own period, which shortens by a per-channel step on every acceleration interval down to a floor. The block also owns the game run-state FSM and the seconds score counter. It sits between the top-level input conditioning and the main renderer/sound block.

Parameters:
NCH, 3, number of tick channels
CW, 26, width of each period/counter field
ACCEL_CYCLES, 100000000, clk cycles between acceleration events while running
SEC_CYCLES, 50000000, clk cycles per score increment
CRASH_CYCLES, 100000000, clk cycles spent frozen after a collision
SCORE_W, 6, score width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  active-high level; begins the game from IDLE
colision  in  1  active-high level from the collision detector
base_period  in  NCH*CW  per-channel initial period; channel i is at bits [i*CW +: CW]
step  in  NCH*CW  per-channel period decrement applied on each acceleration event
min_period  in  NCH*CW  per-channel period floor; must be >=1
tick  out  NCH  one-cycle pulse per channel
running  out  1  high in state RUN
crashed  out  1  high in state CRASH
accel_pulse  out  1  one-cycle pulse on each acceleration event
score  out  SCORE_W  elapsed running seconds, saturating
crash_blink  out  1  see Optional Feature

Behaviour:
- Reset (asynchronous, active-high) values:
  - state=IDLE
  - all outputs 0
  - period_reg[i]=0, reloaded on the first cycle in IDLE
  - all counters 0
- FSM states: IDLE, RUN, CRASH.
- IDLE:
  - period_reg[i]<=base_period[i] every cycle.
  - Channel counters, accel counter and score are held at 0.
  - start=1 moves to RUN on the next edge.
- RUN:
  - Channel counters, accel counter and second counter advance by 1 per cycle.
  - colision=1 moves to CRASH on the next edge. During that same cycle, ticks still fire normally.
- CRASH:
  - All counters are frozen.
  - crash_cnt counts 0..CRASH_CYCLES-1, then the FSM returns to RUN.
  - On that return: every period_reg[i]<=base_period[i] (speed loss), every channel counter <=0, and the accel counter <=0. score is kept.
  - colision is ignored while in CRASH.
- Channel i tick:
  - In RUN, when cnt[i] >= period_reg[i]-1: tick[i]=1 and cnt[i]<=0.
  - Otherwise cnt[i]<=cnt[i]+1.
  - The >= compare makes a period shortened below the current count fire on the next cycle rather than wrap.
  - tick is combinational from registered state and is only ever high in RUN.
- Acceleration:
  - In RUN, when accel_cnt==ACCEL_CYCLES-1: accel_pulse=1 and accel_cnt<=0.
  - On that pulse, each period_reg[i] <= max(period_reg[i]-step[i], min_period[i]).
  - The subtraction is computed CW+1 bits wide, so underflow clamps to the floor.
- Simultaneous accel event and colision: the accel is applied in that cycle, then the CRASH exit restores base periods.
- Score:
  - In RUN, when sec_cnt==SEC_CYCLES-1: sec_cnt<=0 and score<=score+1.
  - score saturates at 2^SCORE_W-1 (no wrap). score is cleared only by reset.
- start is ignored outside IDLE. There is no return to IDLE except via reset.
- running and crashed are registered FSM decodes.

Optional Feature:
Macro: GAME_PACER_BLINK_EN
- Defined:
  - crash_blink toggles every 2^(CW/2) cycles while in CRASH, driven by a free-running counter that is cleared on CRASH entry.
  - crash_blink starts at 1 on the first CRASH cycle and is 0 outside CRASH.
  - The top level uses it for red flash.
- Undefined: crash_blink is tied to 0 and the blink counter is not instantiated.

Test Plan:
- Bench params: NCH=2, CW=8, ACCEL_CYCLES=20, SEC_CYCLES=10, CRASH_CYCLES=5, SCORE_W=3.
1. Reset, base_period={8,4} with channel 1 in the high field, start held 0 for 50 cycles -> tick=0, running=0, score=0. Pulse start -> running=1 one edge later; tick[0] every 4 cycles and tick[1] every 8 cycles, the first one 4/8 cycles after RUN entry.
2. step={2,1}, min_period={3,2}, run 100 cycles -> accel_pulse at RUN cycles 20,40,60,80,100. Channel 0 period goes 4,3,2,2,... (floor 2); channel 1 goes 8,6,4,3,3 (floor 3); tick spacing matches after each pulse.
3. Assert colision in RUN with cnt[0]=1 -> crashed=1 next edge, no ticks for 5 cycles, then running=1. Periods are back to {8,4} and the first tick[0] comes 4 cycles after resuming. score is unchanged across CRASH.
4. Run 80 RUN cycles -> score=7 at cycle 70 and stays 7 (saturated) at cycle 80.
5. Assert reset mid-CRASH and mid-RUN -> all outputs 0 immediately (asynchronous), state IDLE; the next start gives base periods.
6. With GAME_PACER_BLINK_EN (CW=8, blink half-period 16) and CRASH_CYCLES=40 -> crash_blink=1 for CRASH cycles 0-15, 0 for 16-31, 1 for 32-39, and 0 after exit. Without the macro, crash_blink=0 throughout.
